// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// HH:MM:SS countdown. The user loads the time with the mode/val controls,
// starts it, and it decrements once per second down to 00:00:00. At zero it
// holds in EXPIRED with done high and blink toggling. The time outputs are
// binary fields; BCD conversion for the 7-segment path happens downstream.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   val        set value (SW[5:0]), loaded into the field selected by mode
//   mode_btn   mode-cycle button, active-high level
//   start_btn  start/pause/acknowledge button, active-high level
//   segundos   remaining seconds 0..59
//   minutos    remaining minutes 0..59
//   horas      remaining hours 0..23
//   mode       0=count, 1=set hours, 2=set minutes, 3=set seconds
//   running    high in RUN
//   done       high in EXPIRED
//   blink      toggles every BLINK_TICKS cycles in EXPIRED, 0 otherwise
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned BLINK_TICKS   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] val,
    input  logic       mode_btn,
    input  logic       start_btn,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [4:0] horas,
    output logic [1:0] mode,
    output logic       running,
    output logic       done,
    output logic       blink
);

    localparam int DIV_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BLK_W = (BLINK_TICKS   > 1) ? $clog2(BLINK_TICKS)   : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hr_q, hr_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blink_q, blink_d;
    logic             mode_prev_q, start_prev_q;

    logic mode_edge, start_edge, time_nz, tick;

    assign mode_edge  = mode_btn  & ~mode_prev_q;
    assign start_edge = start_btn & ~start_prev_q;
    assign time_nz    = |{hr_q, min_q, sec_q};

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hr_d      = hr_q;
        mode_d    = mode_q;
        div_d     = div_q;
        blk_cnt_d = blk_cnt_q;
        blink_d   = blink_q;
        tick      = 1'b0;

        // Buttons: a mode edge takes priority and swallows a coincident
        // start edge. Leaving count mode pauses a run / acknowledges expiry.
        if (mode_edge) begin
            mode_d = mode_q + 2'd1;
            if (mode_q == 2'd0) begin
                if (state_q == S_RUN)          state_d = S_PAUSED;
                else if (state_q == S_EXPIRED) state_d = S_IDLE;
            end
        end else if (start_edge && (mode_q == 2'd0)) begin
            unique case (state_q)
                S_IDLE, S_PAUSED: if (time_nz) state_d = S_RUN;
                S_RUN:            state_d = S_PAUSED;
                S_EXPIRED:        state_d = S_IDLE;
                default:          ;
            endcase
        end

        // Set modes load continuously; out-of-range values are ignored.
        unique case (mode_q)
            2'd1:    if (val <= 6'd23) hr_d  = val[4:0];
            2'd2:    if (val <= 6'd59) min_d = val;
            2'd3:    if (val <= 6'd59) sec_d = val;
            default: ;
        endcase

        // Divider restarts on every entry to RUN so the first decrement is
        // a full second after the start edge. Only a run that stays a run
        // this cycle may tick.
        if (state_q != S_RUN && state_d == S_RUN) begin
            div_d = '0;
        end else if (state_q == S_RUN && state_d == S_RUN) begin
            if (div_q == DIV_W'(TICKS_PER_SEC - 1)) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        // RUN is only reachable with a nonzero time, so the borrow chain
        // never underflows past 00:00:00.
        if (tick) begin
            if (sec_q != 6'd0) begin
                sec_d = sec_q - 6'd1;
            end else begin
                sec_d = 6'd59;
                if (min_q != 6'd0) begin
                    min_d = min_q - 6'd1;
                end else begin
                    min_d = 6'd59;
                    hr_d  = hr_q - 5'd1;
                end
            end
            if (~|{hr_d, min_d, sec_d}) state_d = S_EXPIRED;
        end

        // Blink runs only while staying in EXPIRED; entry and exit clear it.
        if (state_q == S_EXPIRED && state_d == S_EXPIRED) begin
            if (blk_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
                blk_cnt_d = '0;
                blink_d   = ~blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end else begin
            blk_cnt_d = '0;
            blink_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sec_q        <= '0;
            min_q        <= '0;
            hr_q         <= '0;
            mode_q       <= '0;
            div_q        <= '0;
            blk_cnt_q    <= '0;
            blink_q      <= 1'b0;
            // A button held through reset must be released before it counts.
            mode_prev_q  <= 1'b1;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hr_q         <= hr_d;
            mode_q       <= mode_d;
            div_q        <= div_d;
            blk_cnt_q    <= blk_cnt_d;
            blink_q      <= blink_d;
            mode_prev_q  <= mode_btn;
            start_prev_q <= start_btn;
        end
    end

    assign segundos = sec_q;
    assign minutos  = min_q;
    assign horas    = hr_q;
    assign mode     = mode_q;
    assign running  = (state_q == S_RUN);
    assign done     = (state_q == S_EXPIRED);
    assign blink    = blink_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown companion to the lab's up-counting watch: user loads HH:MM:SS with the same SW/KEY style, starts it, and it decrements once per second to 00:00:00.
- At 00:00:00 it raises `done` and a blink flag.
- Feeds the same 7-segment display path as the watch; outputs are binary fields, and BCD conversion happens downstream.

Parameters:
- TICKS_PER_SEC, 50_000_000, clk cycles per 1 s tick. Use 4 in simulation.
- BLINK_TICKS, 25_000_000, clk cycles per blink half-period while expired. Use 2 in simulation.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- val  in  6  set value (SW[5:0])
- mode_btn  in  1  mode-cycle button, active-high level (KEY[2], already synchronised/inverted)
- start_btn  in  1  start/pause/acknowledge button, active-high level (KEY[1])
- segundos  out  6  remaining seconds, 0..59
- minutos  out  6  remaining minutes, 0..59
- horas  out  5  remaining hours, 0..23
- mode  out  2  0=count, 1=set hours, 2=set minutes, 3=set seconds
- running  out  1  high while in state RUN
- done  out  1  high while in state EXPIRED
- blink  out  1  toggling flag while EXPIRED; 0 otherwise

Behaviour:
- **Reset.**
  - Time fields = 0; mode = 0; state = IDLE; running = done = blink = 0.
  - Divider counters = 0.
  - Button-previous registers = 1, so a button held through reset gives no edge until it is released and pressed again.
- **Edge detect.**
  - An edge is `btn & ~btn_prev`, with `btn_prev` registered every cycle.
  - The action commits at the same clk edge that samples btn=1 with prev=0, so it is visible one cycle after btn rises.
  - Holding the button produces exactly one edge.
- **Mode cycling.** A mode_btn edge does mode <= mode+1, wrapping 3 -> 0.
- **Set modes (1/2/3).** Every cycle, load val into the selected field:
  - hours: only if val <= 23;
  - minutes/seconds: only if val <= 59;
  - out-of-range val leaves the field unchanged.
- **Effect of entering a set mode.** When the mode_btn edge moves 0 -> 1:
  - RUN -> PAUSED;
  - EXPIRED -> IDLE (done and blink clear).
- **start_btn in set modes.** Ignored.
- **State machine** (acts only in mode 0), on a start_btn edge:
  - IDLE -> RUN, only if the time is nonzero; with a zero time, stay IDLE.
  - RUN -> PAUSED.
  - PAUSED -> RUN, only if the time is nonzero.
  - EXPIRED -> IDLE.
- **Divider.**
  - Counts only in RUN.
  - Cleared to 0 on every transition into RUN.
  - A tick pulse occurs when the count reaches TICKS_PER_SEC-1; the count then wraps to 0.
  - So the first decrement lands exactly TICKS_PER_SEC cycles after the start edge commits.
- **Decrement on tick.**
  - seg > 0: seg - 1.
  - seg == 0: seg <= 59, and
    - min > 0: min - 1;
    - min == 0: min <= 59 and hours - 1.
  - If the result is 00:00:00: state -> EXPIRED in the same cycle.
  - A wrap below 00:00:00 can never occur.
- **Other tick conditions.** No tick in IDLE, PAUSED or EXPIRED; fields hold.
- **EXPIRED blink.**
  - A separate counter toggles blink every BLINK_TICKS cycles.
  - blink is forced to 0 and the counter cleared on leaving EXPIRED.
- **Simultaneous mode_btn and start_btn edges.** The mode change wins; the start edge is discarded.
- **Reset mid-run.** All state returns to reset values on the next clk edge; no tick is lost or emitted afterwards.

Test Plan:
1. **Load and start.**
   - Stimulus: reset; mode_btn x1, val=1; mode_btn x1, val=2; mode_btn x1, val=3; mode_btn x1 -> 01:02:03, mode=0, IDLE. Then start_btn pulse.
   - Expected: running=1. After 4 cycles (TICKS_PER_SEC=4): 01:02:02. After 3 further ticks: 01:01:59.
2. **Borrow chain.**
   - Stimulus: load 01:00:00, start; 1 tick.
   - Expected: 00:59:59, done=0.
3. **Expiry.**
   - Stimulus: load 00:00:02, start.
   - Expected: after 2 ticks 00:00:00 and done=1, running=0 in the same cycle as the tick. blink toggles every 2 cycles. Further ticks never occur; fields stay 0.
   - Stimulus: start_btn pulse.
   - Expected: IDLE, done=0, blink=0.
4. **Range and zero guards.**
   - Stimulus: set hours with val=24, then val=23.
   - Expected: val=24 leaves hours unchanged; val=23 loads 23.
   - Stimulus: set minutes with val=60.
   - Expected: minutes unchanged.
   - Stimulus: start_btn with 00:00:00 in mode 0.
   - Expected: stays IDLE, running=0.
5. **Pause/resume and set-while-running.**
   - Stimulus: running from 00:00:10; pause after 2 cycles.
   - Expected: fields frozen at 00:00:10 for 20 cycles.
   - Stimulus: resume.
   - Expected: next decrement exactly 4 cycles later.
   - Stimulus: mode_btn during RUN.
   - Expected: PAUSED, mode=1.
6. **Buttons held and simultaneous edges.**
   - Stimulus: mode_btn held high for 10 cycles.
   - Expected: mode advances by exactly 1.
   - Stimulus: mode_btn and start_btn rising in the same cycle from IDLE.
   - Expected: mode=1, state IDLE.
   - Stimulus: reset asserted mid-RUN.
   - Expected: all outputs 0 on the next edge.
